// File: rtl/vseq_beat_issuer_pkg.sv
// Shared parameters and types for the vector beat issuer.
package vseq_beat_issuer_pkg;
  localparam int VLEN       = 16384;
  localparam int VLMAX      = VLEN / 8;
  localparam int VL_BITS    = $clog2(VLMAX) + 1;
  localparam int DATA_WIDTH = 64;
  localparam int BW         = DATA_WIDTH / 8;
  localparam int TAG_BITS   = 4;
  localparam int SEW_BITS   = 3;

  typedef struct packed {
    logic                vill;
    logic [SEW_BITS-1:0] vsew;
  } vtype_t;

  typedef enum logic [1:0] {IDLE, RUN, SKIP} vseq_state_t;

  typedef struct packed {
    logic [VL_BITS-1:0]  idx;
    logic [BW-1:0]       be;
    logic                first;
    logic                last;
    logic [TAG_BITS-1:0] tag;
  } vseq_beat_t;
endpackage

// File: rtl/vseq_be_gen.sv
// Byte-enable and last-beat generation from remaining element count and sew.
module vseq_be_gen
  import vseq_beat_issuer_pkg::*;
(
  input  logic [VL_BITS-1:0] rem_i,
  input  logic [1:0]         sew_i,
  output logic [BW-1:0]      be_o,
  output logic               last_o
);
  localparam int W = VL_BITS + 3;

  logic [W-1:0] rem_w, epb_w, nbytes_w, mask_w;

  // Widened so rem << sew cannot overflow ahead of the compare.
  always_comb begin
    rem_w    = W'(rem_i);
    epb_w    = W'(BW) >> sew_i;
    nbytes_w = rem_w << sew_i;
    mask_w   = (W'(1) << nbytes_w) - W'(1);
    last_o   = (rem_w <= epb_w);
    be_o     = (rem_w >= epb_w) ? '1 : mask_w[BW-1:0];
  end
endmodule

// File: rtl/vseq_beat_issuer.sv
// Sequences one configured vector instruction into element-group beats.
module vseq_beat_issuer
  import vseq_beat_issuer_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [VL_BITS-1:0]  in_vl_i,
  input  logic [2:0]          in_vsew_i,
  input  logic                in_vill_i,
  input  logic [TAG_BITS-1:0] in_tag_i,
  input  logic                kill_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [VL_BITS-1:0]  out_idx_o,
  output logic [BW-1:0]       out_be_o,
  output logic                out_first_o,
  output logic                out_last_o,
  output logic [TAG_BITS-1:0] out_tag_o,
  output logic                done_o,
  output logic [TAG_BITS-1:0] done_tag_o
);
  vseq_state_t         state_q;
  vseq_beat_t          beat_q;
  logic                valid_q, done_q;
  logic [TAG_BITS-1:0] done_tag_q;
  logic [VL_BITS-1:0]  rem_q, rem_d, epb;
  logic [1:0]          sew_q, sew_d;
  logic [BW-1:0]       be_d;
  logic                last_d, skip;

  // In IDLE the generator looks at the incoming instruction, otherwise at the next beat.
  always_comb begin
    epb   = VL_BITS'(BW) >> sew_q;
    sew_d = sew_q;
    rem_d = rem_q - epb;
    if (state_q == IDLE) begin
      sew_d = in_vsew_i[1:0];
      rem_d = in_vl_i;
    end
    skip = in_vill_i | (in_vsew_i > 3'd3) | (in_vl_i == '0);
  end

  vseq_be_gen u_be_gen (
    .rem_i  (rem_d),
    .sew_i  (sew_d),
    .be_o   (be_d),
    .last_o (last_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      beat_q     <= '0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      done_tag_q <= '0;
      rem_q      <= '0;
      sew_q      <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_valid_i) begin
            sew_q <= sew_d;
            rem_q <= rem_d;
            if (skip) begin
              state_q    <= SKIP;
              done_q     <= 1'b1;
              done_tag_q <= in_tag_i;
            end else begin
              state_q      <= RUN;
              valid_q      <= 1'b1;
              beat_q.idx   <= '0;
              beat_q.be    <= be_d;
              beat_q.first <= 1'b1;
              beat_q.last  <= last_d;
              beat_q.tag   <= in_tag_i;
            end
          end
        end
        RUN: begin
          if (kill_i) begin
            state_q      <= IDLE;
            valid_q      <= 1'b0;
            beat_q.first <= 1'b0;
            beat_q.last  <= 1'b0;
          end else if (out_ready_i) begin
            if (beat_q.last) begin
              state_q      <= IDLE;
              valid_q      <= 1'b0;
              beat_q.first <= 1'b0;
              beat_q.last  <= 1'b0;
              done_q       <= 1'b1;
              done_tag_q   <= beat_q.tag;
            end else begin
              rem_q        <= rem_d;
              beat_q.idx   <= beat_q.idx + 1'b1;
              beat_q.be    <= be_d;
              beat_q.first <= 1'b0;
              beat_q.last  <= last_d;
            end
          end
        end
        SKIP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = valid_q;
  assign out_idx_o   = beat_q.idx;
  assign out_be_o    = beat_q.be;
  assign out_first_o = beat_q.first;
  assign out_last_o  = beat_q.last;
  assign out_tag_o   = beat_q.tag;
  assign done_o      = done_q;
  assign done_tag_o  = done_tag_q;
endmodule

// File: tb/tb_vseq_beat_issuer.sv
// Directed plus randomized bench for vseq_beat_issuer with a beat-list reference model.
module tb_vseq_beat_issuer;
  import vseq_beat_issuer_pkg::*;

  localparam int NBYTES = DATA_WIDTH / 8;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [VL_BITS-1:0]  in_vl = '0;
  logic [2:0]          in_vsew = '0;
  logic                in_vill = 1'b0;
  logic [TAG_BITS-1:0] in_tag = '0;
  logic                kill = 1'b0;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic [VL_BITS-1:0]  out_idx;
  logic [BW-1:0]       out_be;
  logic                out_first, out_last;
  logic [TAG_BITS-1:0] out_tag;
  logic                done;
  logic [TAG_BITS-1:0] done_tag;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  always #5 clk = ~clk;

  vseq_beat_issuer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_vl_i     (in_vl),
    .in_vsew_i   (in_vsew),
    .in_vill_i   (in_vill),
    .in_tag_i    (in_tag),
    .kill_i      (kill),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_idx_o   (out_idx),
    .out_be_o    (out_be),
    .out_first_o (out_first),
    .out_last_o  (out_last),
    .out_tag_o   (out_tag),
    .done_o      (done),
    .done_tag_o  (done_tag)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Called and returns at a negedge with the issuer expected idle.
  // rmode: 0 always ready, 1 random, 2 repeating 1,0,0,1. kill_at: beat index to kill on, -1 none.
  task automatic run_instr(input int vl, input int sew, input bit vill, input int tag,
                           input int rmode, input int kill_at);
    int exp_be[$];
    int epb, nb, b, cyc, n, bytes;
    bit skip;
    bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    skip = vill || (sew > 3) || (vl == 0);
    epb  = skip ? 1 : (NBYTES >> sew);
    nb   = skip ? 0 : (vl + epb - 1) / epb;
    for (int i = 0; i < nb; i++) begin
      n     = (vl - i * epb < epb) ? (vl - i * epb) : epb;
      bytes = n * (1 << sew);
      exp_be.push_back((bytes >= NBYTES) ? ((1 << NBYTES) - 1) : ((1 << bytes) - 1));
    end

    check("in_ready_idle", 32'(in_ready), 1);
    in_valid = 1'b1;
    in_vl    = VL_BITS'(vl);
    in_vsew  = 3'(sew);
    in_vill  = vill;
    in_tag   = TAG_BITS'(tag);
    @(negedge clk);
    in_valid = 1'b0;
    in_vill  = 1'b0;

    if (skip) begin
      check("skip_done", 32'(done), 1);
      check("skip_done_tag", 32'(done_tag), 32'(tag & 15));
      check("skip_no_valid", 32'(out_valid), 0);
      check("skip_busy", 32'(in_ready), 0);
      @(negedge clk);
      check("skip_done_once", 32'(done), 0);
      check("skip_no_valid2", 32'(out_valid), 0);
      return;
    end

    b   = 0;
    cyc = 0;
    while (1) begin
      if (cyc > 4000) begin
        check("beat_timeout", 32'(b), 32'(nb));
        return;
      end
      if (b < nb) begin
        check("valid", 32'(out_valid), 1);
        check("busy", 32'(in_ready), 0);
        check("no_early_done", 32'(done), 0);
        check("idx", 32'(out_idx), 32'(b));
        check("be", 32'(out_be), 32'(exp_be[b]));
        check("first", 32'(out_first), 32'(b == 0));
        check("last", 32'(out_last), 32'(b == nb - 1));
        check("tag", 32'(out_tag), 32'(tag & 15));
        if (b == kill_at) begin
          kill      = 1'b1;
          out_ready = 1'b0;
          @(negedge clk);
          kill = 1'b0;
          check("kill_valid_low", 32'(out_valid), 0);
          check("kill_no_done", 32'(done), 0);
          check("kill_ready", 32'(in_ready), 1);
          return;
        end
        case (rmode)
          0:       out_ready = 1'b1;
          1:       out_ready = 1'($urandom_range(0, 1));
          default: out_ready = pat[cyc % 4];
        endcase
        @(negedge clk);
        if (out_ready) b++;
        cyc++;
      end else begin
        out_ready = 1'b0;
        check("done", 32'(done), 1);
        check("done_tag", 32'(done_tag), 32'(tag & 15));
        check("done_valid_low", 32'(out_valid), 0);
        check("done_ready", 32'(in_ready), 1);
        return;
      end
    end
  endtask

  initial begin
    #3;
    check("rst_ready", 32'(in_ready), 1);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_done", 32'(done), 0);
    check("rst_idx", 32'(out_idx), 0);
    check("rst_be", 32'(out_be), 0);
    check("rst_flags", {30'd0, out_first, out_last}, 0);
    check("rst_tags", {24'd0, out_tag, done_tag}, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_instr(20, 0, 1'b0, 1, 0, -1);
    run_instr(3, 3, 1'b0, 2, 0, -1);
    run_instr(5, 2, 1'b0, 3, 0, -1);
    run_instr(7, 1, 1'b0, 4, 0, -1);
    run_instr(0, 0, 1'b0, 5, 0, -1);
    run_instr(9, 0, 1'b1, 6, 0, -1);
    run_instr(4, 5, 1'b0, 7, 0, -1);
    run_instr(16, 0, 1'b0, 8, 2, -1);
    run_instr(32, 0, 1'b0, 9, 0, 1);
    run_instr(8, 0, 1'b0, 10, 0, -1);
    run_instr(1, 3, 1'b0, 11, 1, -1);

    for (int k = 0; k < 24; k++) begin
      run_instr(int'($urandom_range(0, 70)), int'($urandom_range(0, 3)),
                1'($urandom_range(0, 7) == 0), int'($urandom_range(0, 15)), 1, -1);
    end

    // Asynchronous reset between edges while beats are in flight.
    in_valid  = 1'b1;
    in_vl     = VL_BITS'(32);
    in_vsew   = 3'd0;
    in_tag    = 4'd12;
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("pre_rst_valid", 32'(out_valid), 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 0);
    check("arst_done", 32'(done), 0);
    check("arst_ready", 32'(in_ready), 1);
    check("arst_idx", 32'(out_idx), 0);
    out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_no_done", 32'(done), 0);
    run_instr(VLMAX, 0, 1'b0, 13, 0, -1);
    @(negedge clk);
    check("vlmax_done_once", 32'(done), 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
